// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - streams K*K pixel/weight float pairs from local buffers into a MAC PE.
// Optional PE sum capture register and ports: define MAC_FEEDER_CAPTURE_EN.
module mac_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int K          = 5,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  wr_en,
   input  logic                  wr_sel,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
`ifdef MAC_FEEDER_CAPTURE_EN
   input  logic [DATA_WIDTH-1:0] pe_result,
   output logic [DATA_WIDTH-1:0] sum_out,
`endif
   output logic [DATA_WIDTH-1:0] floatA,
   output logic [DATA_WIDTH-1:0] floatB,
   output logic                  pe_reset,
   output logic                  busy,
   output logic                  done
);

   localparam int KK = K * K;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(KK - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_DONE} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [DATA_WIDTH-1:0] r_pix [KK];
   logic [DATA_WIDTH-1:0] r_wgt [KK];
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic                  r_pe_reset;
   logic                  r_busy;
   logic                  r_done;

   logic [ADDR_WIDTH-1:0] w_next_idx;
   logic                  w_wr_ok;

   assign w_next_idx = r_idx + 1'b1;
   assign w_wr_ok    = wr_en && !r_busy && (wr_addr <= LAST_IDX);

   // Buffers are deliberately left out of reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         if (wr_sel) r_wgt[wr_addr] <= wr_data;
         else        r_pix[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_pe_reset <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_CLEAR;
                  r_pe_reset <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_state    <= S_FEED;
               r_pe_reset <= 1'b0;
               r_idx      <= '0;
               r_a        <= r_pix[0];
               r_b        <= r_wgt[0];
            end
            S_FEED: begin
               if (r_idx == LAST_IDX) begin
                  r_state <= S_DONE;
                  r_a     <= '0;
                  r_b     <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= w_next_idx;
                  r_a   <= r_pix[w_next_idx];
                  r_b   <= r_wgt[w_next_idx];
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MAC_FEEDER_CAPTURE_EN
   logic [DATA_WIDTH-1:0] r_sum;

   // The PE holds its final sum during DONE; latch it as that cycle closes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  r_sum <= '0;
      else if (r_state == S_DONE) r_sum <= pe_result;
   end

   assign sum_out = r_sum;
`endif

   assign floatA   = r_a;
   assign floatB   = r_b;
   assign pe_reset = r_pe_reset;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - directed self-checking bench for mac_feeder with a real-valued PE model.
// Back-to-back capture checks are built when MAC_FEEDER_CAPTURE_EN is defined.
module tb_mac_feeder;

   localparam int DW = 32;
   localparam int K  = 5;
   localparam int AW = 5;
   localparam int KK = K * K;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] floatA;
   logic [DW-1:0] floatB;
   logic          pe_reset;
   logic          busy;
   logic          done;
`ifdef MAC_FEEDER_CAPTURE_EN
   logic [DW-1:0] pe_result;
   logic [DW-1:0] sum_out;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] m_pix [KK];
   logic [31:0] m_wgt [KK];
   real         acc = 0.0;
   int          n;

   always #5 clk = ~clk;

   mac_feeder #(.DATA_WIDTH(DW), .K(K), .ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
`ifdef MAC_FEEDER_CAPTURE_EN
      .pe_result(pe_result),
      .sum_out  (sum_out),
`endif
      .floatA   (floatA),
      .floatB   (floatB),
      .pe_reset (pe_reset),
      .busy     (busy),
      .done     (done)
   );

   function automatic real f2r(input logic [31:0] b);
      real r;
      int  e;
      if (b[30:0] == 31'd0) return 0.0;
      r = 1.0 + real'(b[22:0]) / 8388608.0;
      e = int'(b[30:23]) - 127;
      while (e > 0) begin r = r * 2.0; e--; end
      while (e < 0) begin r = r / 2.0; e++; end
      return b[31] ? -r : r;
   endfunction

   function automatic logic [31:0] r2f(input real v);
      real         r;
      int          e;
      logic        s;
      logic [22:0] m;
      if (v == 0.0) return 32'h0;
      s = (v < 0.0);
      r = s ? -v : v;
      e = 127;
      while (r >= 2.0) begin r = r / 2.0; e++; end
      while (r < 1.0)  begin r = r * 2.0; e--; end
      m = 23'(longint'((r - 1.0) * 8388608.0));
      return {s, 8'(e), m};
   endfunction

   // Free-running PE: clears on pe_reset, otherwise accumulates floatA*floatB every edge.
   always @(posedge clk) begin
      if (pe_reset) acc <= 0.0;
      else          acc <= acc + f2r(floatA) * f2r(floatB);
   end

`ifdef MAC_FEEDER_CAPTURE_EN
   assign pe_result = r2f(acc);
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic write_buf(input logic sel, input logic [AW-1:0] addr, input logic [31:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
      @(posedge clk);
      #1 wr_en = 1'b0;
      if (int'(addr) < KK) begin
         if (sel) m_wgt[addr] = data;
         else     m_pix[addr] = data;
      end
   endtask

   task automatic fill(input logic [31:0] pv, input logic [31:0] wv);
      for (int i = 0; i < KK; i++) begin
         write_buf(1'b0, AW'(i), pv);
         write_buf(1'b1, AW'(i), wv);
      end
   endtask

   task automatic run_job(input logic [31:0] exp_sum, input bit disturb);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("clear_pe_reset", pe_reset, 1);
      check("clear_busy", busy, 1);
      check("clear_floatA", floatA, 0);
      for (int i = 0; i < KK; i++) begin
         @(negedge clk);
         start = 1'b0; wr_en = 1'b0;
         check($sformatf("feed_a[%0d]", i), floatA, m_pix[i]);
         check($sformatf("feed_b[%0d]", i), floatB, m_wgt[i]);
         check($sformatf("feed_pe_reset[%0d]", i), pe_reset, 0);
         check($sformatf("feed_done[%0d]", i), done, 0);
         check($sformatf("feed_busy[%0d]", i), busy, 1);
         if (disturb && i == 5) begin
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
         end
      end
      @(negedge clk);
      check("done_at_27", done, 1);
      check("done_floatA", floatA, 0);
      check("done_floatB", floatB, 0);
      check("done_busy", busy, 0);
      check("pe_sum", r2f(acc), exp_sum);
      @(negedge clk);
      check("done_single", done, 0);
      check("idle_busy", busy, 0);
      @(negedge clk);
      check("no_restart", busy, 0);
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!done && cnt < 60);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_floatA", floatA, 0);
      check("rst_floatB", floatB, 0);
      check("rst_pe_reset", pe_reset, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
`ifdef MAC_FEEDER_CAPTURE_EN
      check("rst_sum_out", sum_out, 0);
`endif
      @(negedge clk); reset = 1'b0;

      fill(32'h3F800000, 32'h40000000);
      run_job(32'h42480000, 1'b0);

      run_job(32'h42480000, 1'b1);

      write_buf(1'b0, 5'd25, 32'hDEADBEEF);
      write_buf(1'b1, 5'd31, 32'hDEADBEEF);
      run_job(32'h42480000, 1'b0);

      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      for (int i = 0; i <= 10; i++) @(negedge clk);
      check("abort_idx10_a", floatA, m_pix[10]);
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_floatA", floatA, 0);
      check("abort_floatB", floatB, 0);
      check("abort_pe_reset", pe_reset, 0);
      check("abort_done", done, 0);
      @(posedge clk); #1 reset = 1'b0;
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) n++;
      end
      check("abort_no_done", n, 0);
      check("abort_idle", busy, 0);
      run_job(32'h42480000, 1'b0);

      for (int i = 0; i < KK; i++) begin
         write_buf(1'b0, AW'(i), r2f(real'(i)));
         write_buf(1'b1, AW'(i), (i == KK - 1) ? 32'h3F800000 : 32'h0);
      end
      check("ramp_pix1", m_pix[1], 32'h3F800000);
      run_job(32'h41C00000, 1'b0);

`ifdef MAC_FEEDER_CAPTURE_EN
      fill(32'h3F800000, 32'h40000000);
      @(negedge clk); start = 1'b1;
      wait_done(n);
      check("b2b_latency1", n, 27);
      check("b2b_sum_before", sum_out, 0);
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 32'h40400000;
      @(negedge clk);
      wr_en = 1'b0; m_pix[0] = 32'h40400000;
      check("b2b_sum1", sum_out, 32'h42480000);
      wait_done(n);
      check("b2b_latency2", n, 27);
      check("b2b_sum_hold", sum_out, 32'h42480000);
      start = 1'b0;
      @(negedge clk);
      check("b2b_sum2", sum_out, 32'h42580000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the IEEE-754 single operand width.
REQ-002 SHALL have parameter K, default 5, the kernel edge; one job is K*K products.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, the write-address width (2^ADDR_WIDTH >= K*K).
REQ-004 SHALL have port clk  input  1  clock, rising-edge active.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-007 SHALL have port wr_en  input  1  operand-buffer write strobe.
REQ-008 SHALL have port wr_sel  input  1  write target: 0 = pixel buffer, 1 = weight buffer.
REQ-009 SHALL have port wr_addr  input  ADDR_WIDTH  buffer entry index.
REQ-010 SHALL have port wr_data  input  DATA_WIDTH  float operand to store.
REQ-011 SHALL have port floatA  output  DATA_WIDTH  pixel operand to the multiply-accumulate PE, registered.
REQ-012 SHALL have port floatB  output  DATA_WIDTH  weight operand to the PE, registered.
REQ-013 SHALL have port pe_reset  output  1  accumulator clear to the PE, registered.
REQ-014 SHALL have port busy  output  1  high in CLEAR and FEED.
REQ-015 SHALL have port done  output  1  one-cycle pulse; the PE accumulator holds the final sum in this cycle.

Function
REQ-016 SHALL hold two K*K-entry buffers, pixel and weight, each DATA_WIDTH wide.
REQ-017 SHALL write wr_data to entry wr_addr of the buffer chosen by wr_sel on a clock edge with wr_en=1 and busy=0.
REQ-018 SHALL ignore writes with wr_addr >= K*K, and writes while busy=1.
REQ-019 SHALL implement states IDLE, CLEAR, FEED and DONE.
REQ-020 SHALL move IDLE->CLEAR on an edge with start=1, CLEAR->FEED after one cycle, FEED->DONE after K*K cycles, and DONE->IDLE after one cycle.
REQ-021 SHALL drive pe_reset=1 only in CLEAR.
REQ-022 SHALL present pixel[i] on floatA and weight[i] on floatB in the i-th FEED cycle, for i = 0..K*K-1 in ascending order, one pair per cycle with no gaps.
REQ-023 SHALL drive floatA=floatB=0x00000000 in IDLE, CLEAR and DONE, so a free-running PE accumulates +0.
REQ-024 SHALL assert done in the cycle following the edge that ends the last FEED cycle, i.e. K*K+2 cycles after the start edge.
REQ-025 SHALL ignore start outside IDLE; start held high in DONE SHALL launch the next job from IDLE one cycle later.
REQ-026 SHALL use an index counter of ADDR_WIDTH bits that counts 0..K*K-1 and clears on entry to FEED.

Reset
REQ-027 SHALL, on reset=1, immediately force IDLE, counter=0, floatA=floatB=0, pe_reset=0, busy=0 and done=0.
REQ-028 SHALL abort an in-flight job on reset without issuing done; buffer contents are not reset and are undefined until written.

Configuration
REQ-029 SHALL, with macro MAC_FEEDER_CAPTURE_EN defined, add port pe_result  input  DATA_WIDTH (PE accumulator) and port sum_out  output  DATA_WIDTH (registered, reset to 0).
REQ-030 SHALL, with MAC_FEEDER_CAPTURE_EN defined, load sum_out from pe_result on the clock edge that ends the DONE cycle and hold it until the next done.
REQ-031 SHALL, without MAC_FEEDER_CAPTURE_EN, have neither port nor the capture register; all other behaviour is identical.

Verification
REQ-032 SHALL cover: K=5, all pixels 0x3F800000 (1.0), all weights 0x40000000 (2.0), pulse start -> pe_reset high one cycle, 25 FEED pairs, done at cycle 27 after start, PE sum 0x42480000 (50.0).
REQ-033 SHALL cover: pixel[i] = i as float, weight[24]=0x3F800000, others 0 -> operand order 0..24 on floatA, sum 0x41C00000 (24.0).
REQ-034 SHALL cover: start and wr_en pulsed during FEED -> no restart, buffers unchanged, single done.
REQ-035 SHALL cover: reset asserted at FEED index 10 -> IDLE next cycle, outputs 0, no done; a new start yields a correct 50.0 job.
REQ-036 SHALL cover: write with wr_addr=25 and wr_addr=31 -> ignored, entries 0..24 unchanged.
REQ-037 SHALL cover, with MAC_FEEDER_CAPTURE_EN: back-to-back jobs with start held high -> sum_out=0x42480000 after the first done, updated after the second.
